// File: rtl/shift_pkg.sv
// shift_pkg: shared op and state encodings for the sequential shifter
package shift_pkg;
   localparam logic [1:0] OP_SLL = 2'b00;
   localparam logic [1:0] OP_SRL = 2'b01;
   localparam logic [1:0] OP_SRA = 2'b10;
   localparam logic [1:0] OP_ROR = 2'b11;
   typedef enum logic {IDLE, RUN} state_t;
endpackage

// File: rtl/shift_stage.sv
// shift_stage: one combinational binary stage, shifts by 2^k in the selected mode when enabled
module shift_stage
   import shift_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0]   data,
   input  logic [SHAMT_W-1:0] k,
   input  logic               en,
   input  logic [1:0]         op,
   output logic [WIDTH-1:0]   result
);
   localparam logic [SHAMT_W:0] W_L = (SHAMT_W + 1)'(WIDTH);
   logic [SHAMT_W:0] amt;
   logic [WIDTH-1:0] sra;
   // arithmetic shift kept apart so an unsigned ternary context cannot turn it into a logical shift
   always_comb begin
      amt = en ? ((SHAMT_W + 1)'(1) << k) : '0;
      sra = $signed(data) >>> amt;
      result = op == OP_SLL ? data << amt :
               op == OP_SRL ? data >> amt :
               op == OP_SRA ? sra :
               (data >> amt) | (data << (W_L - amt));
   end
endmodule

// File: rtl/seq_shifter.sv
// seq_shifter: multi-cycle shifter, one binary stage per cycle from the MSB stage down
module seq_shifter
   import shift_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               ctrl_shift,
   input  logic [WIDTH-1:0]   data_operandA,
   input  logic [SHAMT_W-1:0] data_shamt,
   input  logic [1:0]         data_op,
   output logic [WIDTH-1:0]   data_result,
   output logic               data_resultRDY,
   output logic               busy
);
   localparam logic [SHAMT_W-1:0] LAST = SHAMT_W'(SHAMT_W - 1);
   state_t             state;
   logic [SHAMT_W-1:0] cnt;
   logic [SHAMT_W-1:0] shamt;
   logic [1:0]         op;
   logic [WIDTH-1:0]   work;
   logic [WIDTH-1:0]   stage_out;
   shift_stage #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) u_stage (
      .data  (work),
      .k     (cnt),
      .en    (shamt[cnt]),
      .op    (op),
      .result(stage_out)
   );
   // control FSM: latch on start, apply one stage per RUN cycle, publish result with a one-cycle ready pulse
   always_ff @(posedge clock) begin
      if (reset) begin
         state          <= IDLE;
         cnt            <= '0;
         shamt          <= '0;
         op             <= '0;
         work           <= '0;
         data_result    <= '0;
         data_resultRDY <= 1'b0;
         busy           <= 1'b0;
      end else begin
         data_resultRDY <= 1'b0;
         if (state == IDLE) begin
            if (ctrl_shift) begin
               work  <= data_operandA;
               shamt <= data_shamt;
               op    <= data_op;
               cnt   <= LAST;
               state <= RUN;
               busy  <= 1'b1;
            end
         end else begin
            work <= stage_out;
            cnt  <= cnt == '0 ? '0 : cnt - 1'b1;
            if (cnt == '0) begin
               data_result    <= stage_out;
               data_resultRDY <= 1'b1;
               busy           <= 1'b0;
               state          <= IDLE;
            end
         end
      end
   end
endmodule
